// File: rtl/apb4_ram_completer.sv
// apb4_ram_completer: APB4 completer in front of a word-addressed on-chip RAM.
// It supports byte-lane writes through PSTRB and a fixed number of wait states
// per access. It flags misaligned addresses, out-of-range addresses and reads
// with non-zero strobes, and counts error-terminated transfers in a
// saturating 8-bit counter.
module apb4_ram_completer #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic [7:0]              err_count
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(NBYTES);
    localparam int IDX_W  = ADDR_WIDTH - LSB;
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [RAM_AW-1:0]       ram_idx_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NBYTES-1:0]       strb_q;
    logic                    err_q;
    logic [7:0]              err_count_q;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic [IDX_W-1:0]        idx_d;
    logic                    misaligned_d;
    logic                    out_of_range_d;
    logic                    err_d;
    logic                    setup_phase;
    logic                    complete;

    // Decode the word index from the byte address.
    assign idx_d = PADDR[ADDR_WIDTH-1:LSB];

    // Byte-wide RAM has no sub-word offset, so it can never be misaligned.
    generate
        if (LSB > 0) begin : g_align
            assign misaligned_d = |PADDR[LSB-1:0];
        end else begin : g_no_align
            assign misaligned_d = 1'b0;
        end
    endgenerate

    // The extra top bit keeps the compare correct when DEPTH fills the whole index space.
    assign out_of_range_d = {1'b0, idx_d} >= (IDX_W + 1)'(DEPTH);
    assign err_d          = misaligned_d | out_of_range_d | (!PWRITE && (|PSTRB));

    // A setup phase is accepted in any state, which also covers a restart during ACCESS.
    assign setup_phase = PSEL && !PENABLE;
    assign complete    = (state_q == ACCESS) && PSEL && PENABLE && (cnt_q == 4'd0);

    // Transfer sequencing: capture on setup, count wait states, finish on completion.
    // NOTE: every register in a clocked block uses <= so all of them update together
    // from the pre-edge values; a blocking = here would leak new values into later lines.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            ram_idx_q   <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            strb_q      <= '0;
            err_q       <= 1'b0;
            err_count_q <= 8'd0;
        end else if (setup_phase) begin
            state_q   <= ACCESS;
            cnt_q     <= WS;
            ram_idx_q <= idx_d[RAM_AW-1:0];
            write_q   <= PWRITE;
            wdata_q   <= PWDATA;
            strb_q    <= PSTRB;
            err_q     <= err_d;
        end else if (state_q == ACCESS) begin
            if (!PSEL) begin
                state_q <= IDLE;
            end else if (cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end else begin
                state_q <= IDLE;
                if (err_q && (err_count_q != 8'hFF)) begin
                    err_count_q <= err_count_q + 8'd1;
                end
            end
        end
    end

    // Storage array: cleared on reset, byte-lane writes on an error-free write completion.
    // NOTE: this memory has a reset because a cleared RAM is part of its defined reset
    // state. It forces a register array rather than a RAM macro, which is fine at this size.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (complete && write_q && !err_q) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (strb_q[b]) begin
                    mem_q[ram_idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // Response outputs: they are non-zero only in the PREADY cycle, and read data only for a clean read.
    // NOTE: each output gets its default first, so no path can leave a value held and infer a latch.
    always_comb begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        if ((state_q == ACCESS) && (cnt_q == 4'd0)) begin
            PREADY  = 1'b1;
            PSLVERR = err_q;
            if (!write_q && !err_q) begin
                PRDATA = mem_q[ram_idx_q];
            end
        end
    end

    assign err_count = err_count_q;

endmodule

// File: tb/tb_apb4_ram_completer.sv
// tb_apb4_ram_completer: three completer instances (0, 2 and 3 wait states) on
// one shared APB bus with separate selects, driven by directed transfers.
module tb_apb4_ram_completer;

    logic              PCLK    = 1'b0;
    logic              PRESET  = 1'b1;
    logic [31:0]       PADDR   = '0;
    logic [2:0]        psel    = '0;
    logic              PENABLE = 1'b0;
    logic              PWRITE  = 1'b0;
    logic [31:0]       PWDATA  = '0;
    logic [3:0]        PSTRB   = '0;

    logic [2:0][31:0]  prdata_w;
    logic [2:0]        pready_w;
    logic [2:0]        pslverr_w;
    logic [2:0][7:0]   errc_w;

    int                n_asserts = 0;
    int                n_fail    = 0;
    int unsigned       cyc       = 0;

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc++;

    // Instance 0: WAIT_STATES=0, instance 1: WAIT_STATES=2, instance 2: WAIT_STATES=3.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb4_ram_completer #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .DEPTH      (64),
            .WAIT_STATES((g == 0) ? 0 : g + 1)
        ) u_dut (
            .PCLK     (PCLK),
            .PRESET   (PRESET),
            .PADDR    (PADDR),
            .PSEL     (psel[g]),
            .PENABLE  (PENABLE),
            .PWRITE   (PWRITE),
            .PWDATA   (PWDATA),
            .PSTRB    (PSTRB),
            .PRDATA   (prdata_w[g]),
            .PREADY   (pready_w[g]),
            .PSLVERR  (pslverr_w[g]),
            .err_count(errc_w[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Entered and left one time unit after a rising edge; the next transfer may start at once.
    task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input int exp_wait, input logic [31:0] exp_rdata,
                            input logic exp_err, input string tag);
        int waits;
        psel[d] = 1'b1;
        PENABLE = 1'b0;
        PADDR   = addr;
        PWRITE  = wr;
        PWDATA  = wdata;
        PSTRB   = strb;
        tick();
        PENABLE = 1'b1;
        waits   = 0;
        while (!pready_w[d] && waits < 40) begin
            check({tag, "_wait_rdata"}, prdata_w[d], 32'h0);
            check({tag, "_wait_slverr"}, 32'(pslverr_w[d]), 32'h0);
            waits++;
            tick();
        end
        check({tag, "_waits"}, 32'(waits), 32'(exp_wait));
        check({tag, "_ready"}, 32'(pready_w[d]), 32'h1);
        check({tag, "_rdata"}, prdata_w[d], exp_rdata);
        check({tag, "_slverr"}, 32'(pslverr_w[d]), 32'(exp_err));
        tick();
        psel    = '0;
        PENABLE = 1'b0;
        PSTRB   = '0;
    endtask

    initial begin
        int unsigned c0;

        // Reset held for two edges: all outputs quiet.
        repeat (2) @(posedge PCLK);
        #1;
        check("rst_ready", 32'(pready_w[0]), 32'h0);
        check("rst_slverr", 32'(pslverr_w[0]), 32'h0);
        check("rst_rdata", prdata_w[0], 32'h0);
        check("rst_errc", 32'(errc_w[0]), 32'h0);
        PRESET = 1'b0;
        tick();

        // Every word reads back as zero with a single access cycle.
        for (int i = 0; i < 64; i++) begin
            apb_xfer(0, 1'b0, 32'(i * 4), 32'h0, 4'h0, 0, 32'h0, 1'b0, "sweep");
        end
        check("sweep_errc", 32'(errc_w[0]), 32'h0);

        // Byte strobes.
        apb_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, "wr_full");
        apb_xfer(0, 1'b1, 32'h10, 32'h000000AA, 4'h1, 0, 32'h0, 1'b0, "wr_lane0");
        apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEAA, 1'b0, "rd_lane0");
        apb_xfer(0, 1'b1, 32'h10, 32'h11111111, 4'h0, 0, 32'h0, 1'b0, "wr_nostrb");
        apb_xfer(0, 1'b1, 32'h10, 32'h55660000, 4'hC, 0, 32'h0, 1'b0, "wr_hi");
        apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'h5566BEAA, 1'b0, "rd_hi");

        // Error responses; index 64 must not alias onto index 0.
        apb_xfer(0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1'b1, "err_range");
        apb_xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 1'b0, "rd_alias0");
        apb_xfer(0, 1'b0, 32'h102, 32'h0, 4'h0, 0, 32'h0, 1'b1, "err_misalign");
        apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h3, 0, 32'h0, 1'b1, "err_rdstrb");
        apb_xfer(0, 1'b0, 32'hFC, 32'h0, 4'h0, 0, 32'h0, 1'b0, "rd_last");
        check("err_count3", 32'(errc_w[0]), 32'd3);

        // Back-to-back writes and reads, two cycles each.
        c0 = cyc;
        apb_xfer(0, 1'b1, 32'h0, 32'h11111111, 4'hF, 0, 32'h0, 1'b0, "b2b_w0");
        apb_xfer(0, 1'b1, 32'h4, 32'h22222222, 4'hF, 0, 32'h0, 1'b0, "b2b_w1");
        apb_xfer(0, 1'b1, 32'h8, 32'h33333333, 4'hF, 0, 32'h0, 1'b0, "b2b_w2");
        apb_xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, 32'h33333333, 1'b0, "b2b_r2");
        apb_xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 0, 32'h22222222, 1'b0, "b2b_r1");
        apb_xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h11111111, 1'b0, "b2b_r0");
        check("b2b_cycles", cyc - c0, 32'd12);

        // Abort: PSEL dropped during ACCESS, so no write happens.
        psel[0] = 1'b1; PENABLE = 1'b0; PADDR = 32'h20; PWRITE = 1'b1;
        PWDATA = 32'hCAFEF00D; PSTRB = 4'hF;
        tick();
        psel = '0; PSTRB = '0;
        tick();
        check("abort_ready", 32'(pready_w[0]), 32'h0);
        apb_xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'h0, 1'b0, "abort_rd");

        // Restart: a second setup phase during ACCESS replaces the first.
        psel[0] = 1'b1; PENABLE = 1'b0; PADDR = 32'h24; PWRITE = 1'b1;
        PWDATA = 32'hA5A5A5A5; PSTRB = 4'hF;
        tick();
        PADDR = 32'h28; PWDATA = 32'h5A5A5A5A;
        tick();
        PENABLE = 1'b1;
        check("restart_ready", 32'(pready_w[0]), 32'h1);
        tick();
        psel = '0; PENABLE = 1'b0; PSTRB = '0;
        apb_xfer(0, 1'b0, 32'h24, 32'h0, 4'h0, 0, 32'h0, 1'b0, "restart_old");
        apb_xfer(0, 1'b0, 32'h28, 32'h0, 4'h0, 0, 32'h5A5A5A5A, 1'b0, "restart_new");
        check("proto_errc", 32'(errc_w[0]), 32'd3);

        // Two wait states.
        apb_xfer(1, 1'b1, 32'h4, 32'h12345678, 4'hF, 2, 32'h0, 1'b0, "ws2_wr");
        apb_xfer(1, 1'b0, 32'h4, 32'h0, 4'h0, 2, 32'h12345678, 1'b0, "ws2_rd");

        // Saturating error counter.
        for (int i = 0; i < 300; i++) begin
            apb_xfer(0, 1'b0, 32'h100, 32'h0, 4'h0, 0, 32'h0, 1'b1, "sat");
        end
        check("sat_errc", 32'(errc_w[0]), 32'd255);

        // Reset during a three-wait-state write that is already showing PREADY.
        apb_xfer(2, 1'b1, 32'h8, 32'h77777777, 4'hF, 3, 32'h0, 1'b0, "ws3_wr");
        apb_xfer(2, 1'b0, 32'h8, 32'h0, 4'h0, 3, 32'h77777777, 1'b0, "ws3_rd");
        psel[2] = 1'b1; PENABLE = 1'b0; PADDR = 32'h8; PWRITE = 1'b1;
        PWDATA = 32'h99999999; PSTRB = 4'hF;
        tick();
        PENABLE = 1'b1;
        repeat (3) tick();
        check("ws3_pre_rst_ready", 32'(pready_w[2]), 32'h1);
        PRESET = 1'b1;
        #1;
        check("midrst_ready", 32'(pready_w[2]), 32'h0);
        check("midrst_slverr", 32'(pslverr_w[2]), 32'h0);
        check("midrst_rdata", prdata_w[2], 32'h0);
        check("midrst_errc", 32'(errc_w[0]), 32'h0);
        psel = '0; PENABLE = 1'b0; PSTRB = '0;
        tick();
        tick();
        PRESET = 1'b0;
        tick();
        apb_xfer(2, 1'b0, 32'h8, 32'h0, 4'h0, 3, 32'h0, 1'b0, "post_rst_rd");
        apb_xfer(1, 1'b0, 32'h4, 32'h0, 4'h0, 2, 32'h0, 1'b0, "post_rst_ws2");
        apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'h0, 1'b0, "post_rst_ws0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
